led_matrix_scanner: RTL and testbench

- Consumer end of the 16x16 bicolour pixel-array interface: takes the RedPixels/GrnPixels frames produced by display/game logic and scans them onto the physical LED board one row at a time.
- Snapshots a full frame at each frame start (tear-free), then drives one-hot row select plus red/green column data.
- Inserts a blanking gap between rows to suppress ghosting.
- Sits between board-rendering logic and the top-level LED board pins.

---
 rtl/led_matrix_scanner_pkg.sv | 14 +
 rtl/led_matrix_scanner_if.sv | 17 +
 rtl/led_matrix_scanner_scan_timer.sv | 20 ++
 rtl/led_matrix_scanner.sv | 142 ++++++++++++++
 tb/tb_led_matrix_scanner.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_scanner_pkg.sv
// Shared types for the LED matrix scanner: frame layout, scan states, row decode.
package led_pkg;
  localparam int ROWS = 16;

  typedef logic [ROWS-1:0][15:0] pixel_frame_t;

  typedef enum logic [1:0] {IDLE, LOAD, BLANK, DRIVE} scan_state_t;

  function automatic logic [ROWS-1:0] row_onehot(input logic [3:0] r);
    logic [ROWS-1:0] one;
    one = {{(ROWS-1){1'b0}}, 1'b1};
    return one << r;
  endfunction
endpackage

// File: rtl/led_matrix_scanner_if.sv
// Pixel-frame input and LED board drive bundle between renderer and scanner.
interface led_matrix_scanner_if;
  import led_pkg::*;

  logic         Enable;
  pixel_frame_t RedPixels;
  pixel_frame_t GrnPixels;
  logic [15:0]  RowSel;
  logic [15:0]  RedCol;
  logic [15:0]  GrnCol;
  logic         FrameStart;

  modport master (output Enable, RedPixels, GrnPixels,
                  input  RowSel, RedCol, GrnCol, FrameStart);
  modport slave  (input  Enable, RedPixels, GrnPixels,
                  output RowSel, RedCol, GrnCol, FrameStart);
endinterface

// File: rtl/led_matrix_scanner_scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= load_value;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for a 16x16 bicolour LED board with per-frame snapshot
// and optional blanking gap before each row.
module led_matrix_scanner #(
  parameter int DWELL = 1250,
  parameter int BLANK = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  led_matrix_scanner_if.slave  bus
);
  import led_pkg::pixel_frame_t;
  import led_pkg::scan_state_t;
  import led_pkg::row_onehot;

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TW   = $clog2(MAXV + 1);
  // Timer counts down to zero inclusive, so load one less than the length.
  localparam logic [TW-1:0] DW_LD = TW'(DWELL - 1);
  localparam logic [TW-1:0] BL_LD = TW'((BLANK > 0) ? BLANK - 1 : 0);

  scan_state_t  state_q, state_d;
  logic [3:0]   row_q, row_d, nxt_row;
  logic [15:0]  rsel_q, rsel_d, red_q, red_d, grn_q, grn_d;
  logic         fs_q, fs_d, cap;
  pixel_frame_t red_sh_q, grn_sh_q;
  logic         tmr_ld, tmr_done;
  logic [TW-1:0] tmr_val;

  scan_timer #(.W(TW)) u_tmr (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (tmr_ld),
    .load_value(tmr_val),
    .done      (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    nxt_row = row_q + 4'd1;
    rsel_d  = '0;
    red_d   = '0;
    grn_d   = '0;
    fs_d    = 1'b0;
    cap     = 1'b0;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    if (!bus.Enable) begin
      state_d = led_pkg::IDLE;
      tmr_ld  = (state_q != led_pkg::IDLE);
    end else begin
      case (state_q)
        led_pkg::IDLE: begin
          state_d = led_pkg::LOAD;
          fs_d    = 1'b1;
          tmr_ld  = 1'b1;
        end
        led_pkg::LOAD: begin
          cap    = 1'b1;
          row_d  = '0;
          tmr_ld = 1'b1;
          // With no blanking, row 0 comes straight from the frame being captured.
          if (BLANK == 0) begin
            state_d = led_pkg::DRIVE;
            tmr_val = DW_LD;
            rsel_d  = row_onehot(4'd0);
            red_d   = bus.RedPixels[0];
            grn_d   = bus.GrnPixels[0];
          end else begin
            state_d = led_pkg::BLANK;
            tmr_val = BL_LD;
          end
        end
        led_pkg::BLANK: begin
          if (tmr_done) begin
            state_d = led_pkg::DRIVE;
            tmr_ld  = 1'b1;
            tmr_val = DW_LD;
            rsel_d  = row_onehot(row_q);
            red_d   = red_sh_q[row_q];
            grn_d   = grn_sh_q[row_q];
          end
        end
        led_pkg::DRIVE: begin
          if (!tmr_done) begin
            rsel_d = rsel_q;
            red_d  = red_q;
            grn_d  = grn_q;
          end else if (row_q == 4'd15) begin
            state_d = led_pkg::LOAD;
            row_d   = '0;
            fs_d    = 1'b1;
            tmr_ld  = 1'b1;
          end else begin
            row_d  = nxt_row;
            tmr_ld = 1'b1;
            if (BLANK == 0) begin
              state_d = led_pkg::DRIVE;
              tmr_val = DW_LD;
              rsel_d  = row_onehot(nxt_row);
              red_d   = red_sh_q[nxt_row];
              grn_d   = grn_sh_q[nxt_row];
            end else begin
              state_d = led_pkg::BLANK;
              tmr_val = BL_LD;
            end
          end
        end
        default: state_d = led_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= led_pkg::IDLE;
      row_q    <= '0;
      rsel_q   <= '0;
      red_q    <= '0;
      grn_q    <= '0;
      fs_q     <= 1'b0;
      red_sh_q <= '0;
      grn_sh_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rsel_q  <= rsel_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      fs_q    <= fs_d;
      if (cap) begin
        red_sh_q <= bus.RedPixels;
        grn_sh_q <= bus.GrnPixels;
      end
    end
  end

  assign bus.RowSel     = rsel_q;
  assign bus.RedCol     = red_q;
  assign bus.GrnCol     = grn_q;
  assign bus.FrameStart = fs_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench: u0 runs DWELL=4/BLANK=2, u1 runs DWELL=4/BLANK=0 on the same stimulus.
module tb_led_matrix_scanner;
  logic CLK, RST;
  int   n_chk = 0, n_err = 0;

  led_matrix_scanner_if if0();
  led_matrix_scanner_if if1();

  assign if1.Enable    = if0.Enable;
  assign if1.RedPixels = if0.RedPixels;
  assign if1.GrnPixels = if0.GrnPixels;

  led_matrix_scanner #(.DWELL(4), .BLANK(2)) u0 (.CLK(CLK), .RST(RST), .bus(if0));
  led_matrix_scanner #(.DWELL(4), .BLANK(0)) u1 (.CLK(CLK), .RST(RST), .bus(if1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          k;
    logic [15:0] rs, rc, gc;
    logic        fs;
    bit          act;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int k, logic [15:0] rs, logic [15:0] rc, logic [15:0] gc,
                              logic fs, bit act);
    vec_t v;
    v.k = k; v.rs = rs; v.rc = rc; v.gc = gc; v.fs = fs; v.act = act;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Board-level invariants, checked on every sampled cycle for both builds.
  task automatic tick();
    logic bad;
    @(posedge CLK);
    #1;
    bad = ($countones(if0.RowSel) > 1) || ($countones(if1.RowSel) > 1) ||
          (if0.RowSel == 16'h0 && (if0.RedCol != 16'h0 || if0.GrnCol != 16'h0)) ||
          (if1.RowSel == 16'h0 && (if1.RedCol != 16'h0 || if1.GrnCol != 16'h0));
    chk("invariant", {63'h0, bad}, 64'h0);
  endtask

  function automatic logic [48:0] o0();
    return {if0.RowSel, if0.RedCol, if0.GrnCol, if0.FrameStart};
  endfunction

  function automatic logic [48:0] o1();
    return {if1.RowSel, if1.RedCol, if1.GrnCol, if1.FrameStart};
  endfunction

  // u1 first frame with Red[r]=1<<r: LOAD at k=1 and 66, row r lit k=2+4r..5+4r.
  function automatic logic [48:0] u1_exp(int k);
    logic [15:0] oh;
    oh = 16'h0001;
    if (k == 1 || k == 66) return {48'h0, 1'b1};
    oh = oh << ((k - 2) / 4);
    return {oh, oh, 16'h0, 1'b0};
  endfunction

  initial begin
    int k, p0, p1;
    logic idle_bad;

    tbl.push_back(mk(1,   16'h0000, 16'h0000, 16'h0, 1'b1, 0));
    tbl.push_back(mk(2,   16'h0000, 16'h0000, 16'h0, 1'b0, 0));
    tbl.push_back(mk(3,   16'h0000, 16'h0000, 16'h0, 1'b0, 0));
    tbl.push_back(mk(4,   16'h0001, 16'h0001, 16'h0, 1'b0, 0));
    tbl.push_back(mk(7,   16'h0001, 16'h0001, 16'h0, 1'b0, 0));
    tbl.push_back(mk(8,   16'h0000, 16'h0000, 16'h0, 1'b0, 0));
    tbl.push_back(mk(10,  16'h0002, 16'h0002, 16'h0, 1'b0, 0));
    tbl.push_back(mk(28,  16'h0010, 16'h0010, 16'h0, 1'b0, 0));
    tbl.push_back(mk(93,  16'h0000, 16'h0000, 16'h0, 1'b0, 0));
    tbl.push_back(mk(94,  16'h8000, 16'h8000, 16'h0, 1'b0, 0));
    tbl.push_back(mk(97,  16'h8000, 16'h8000, 16'h0, 1'b0, 0));
    tbl.push_back(mk(98,  16'h0000, 16'h0000, 16'h0, 1'b1, 0));
    tbl.push_back(mk(131, 16'h0020, 16'h0020, 16'h0, 1'b0, 1));
    tbl.push_back(mk(133, 16'h0020, 16'h0020, 16'h0, 1'b0, 0));
    tbl.push_back(mk(191, 16'h8000, 16'h8000, 16'h0, 1'b0, 0));
    tbl.push_back(mk(195, 16'h0000, 16'h0000, 16'h0, 1'b1, 0));
    tbl.push_back(mk(198, 16'h0001, 16'hFFFF, 16'h0, 1'b0, 0));
    tbl.push_back(mk(252, 16'h0200, 16'hFFFF, 16'h0, 1'b0, 0));
    tbl.push_back(mk(291, 16'h8000, 16'hFFFF, 16'h0, 1'b0, 0));
    tbl.push_back(mk(292, 16'h0000, 16'h0000, 16'h0, 1'b1, 0));

    // Reset held with Enable high: nothing may light.
    RST = 1'b1;
    if0.Enable = 1'b1;
    if0.RedPixels = '1;
    if0.GrnPixels = '1;
    #1 RST = 1'b0;
    repeat (3) tick();
    chk("rst_u0", o0(), 49'h0);
    chk("rst_u1", o1(), 49'h0);

    RST = 1'b1;
    if0.Enable = 1'b0;
    idle_bad = 1'b0;
    repeat (50) begin
      tick();
      if (o0() != 49'h0 || o1() != 49'h0) idle_bad = 1'b1;
    end
    chk("idle50", {63'h0, idle_bad}, 64'h0);

    // Diagonal red frame, then snapshot change mid row 5 of frame 2.
    for (int r = 0; r < 16; r++) if0.RedPixels[r] = 16'h0001 << r;
    if0.GrnPixels = '0;
    if0.Enable = 1'b1;
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        tick();
        k++;
        if (k <= 66) chk($sformatf("u1_k%0d", k), o1(), u1_exp(k));
      end
      chk($sformatf("u0_k%0d", k), o0(), {tbl[i].rs, tbl[i].rc, tbl[i].gc, tbl[i].fs});
      if (tbl[i].act) if0.RedPixels = '1;
    end

    // Amber row 3, captured by the LOAD in progress at k=292.
    if0.RedPixels = '0;
    if0.GrnPixels = '0;
    if0.RedPixels[3] = 16'hF0F0;
    if0.GrnPixels[3] = 16'hFF00;
    repeat (3) tick();
    chk("amb_row0", o0(), {16'h0001, 16'h0000, 16'h0000, 1'b0});
    repeat (18) tick();
    chk("amb_row3a", o0(), {16'h0008, 16'hF0F0, 16'hFF00, 1'b0});
    repeat (3) tick();
    chk("amb_row3b", o0(), {16'h0008, 16'hF0F0, 16'hFF00, 1'b0});
    repeat (3) tick();
    chk("amb_row4", o0(), {16'h0010, 16'h0000, 16'h0000, 1'b0});
    repeat (18) tick();
    chk("row7", o0(), {16'h0080, 16'h0000, 16'h0000, 1'b0});

    // Enable drop mid row 7, then restart from a fresh LOAD at row 0.
    if0.Enable = 1'b0;
    tick();
    chk("en_drop_u0", o0(), 49'h0);
    chk("en_drop_u1", o1(), 49'h0);
    repeat (5) tick();
    chk("en_hold", o0(), 49'h0);
    if0.Enable = 1'b1;
    tick();
    chk("reen_load", o0(), {48'h0, 1'b1});
    repeat (3) tick();
    chk("reen_row0", o0(), {16'h0001, 16'h0000, 16'h0000, 1'b0});

    // Asynchronous reset between clock edges while row 0 is lit.
    #2 RST = 1'b0;
    #1;
    chk("arst_u0", o0(), 49'h0);
    chk("arst_u1", o1(), 49'h0);
    #2 RST = 1'b1;
    tick();
    chk("rst_load_u0", o0(), {48'h0, 1'b1});
    chk("rst_load_u1", o1(), {48'h0, 1'b1});

    // Frame periods measured from that LOAD.
    p0 = 0;
    p1 = 0;
    for (int c = 1; c <= 300 && (p0 == 0 || p1 == 0); c++) begin
      tick();
      if (p0 == 0 && if0.FrameStart) p0 = c;
      if (p1 == 0 && if1.FrameStart) p1 = c;
    end
    chk("period_u0", 64'(p0), 64'd97);
    chk("period_u1", 64'(p1), 64'd65);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
